// File: rtl/bus_arbiter_if.sv
// Bundle of the two requester ports and the system bus follower port of the
// arbiter. The environment drives through `master`; the arbiter sits on `slave`.
interface bus_arbiter_if;
  logic [31:0] m0_addr, m0_write_data, m0_read_data;
  logic [3:0]  m0_byte_enable;
  logic        m0_read_req, m0_write_req, m0_ack, m0_read_data_valid, m0_error;
  logic [31:0] m1_addr, m1_write_data, m1_read_data;
  logic [3:0]  m1_byte_enable;
  logic        m1_read_req, m1_write_req, m1_ack, m1_read_data_valid, m1_error;
  logic [31:0] s_addr, s_write_data, s_read_data;
  logic [3:0]  s_byte_enable;
  logic        s_read_req, s_write_req, s_read_data_valid;

  modport master (
    output m0_addr, m0_write_data, m0_byte_enable, m0_read_req, m0_write_req,
    output m1_addr, m1_write_data, m1_byte_enable, m1_read_req, m1_write_req,
    output s_read_data, s_read_data_valid,
    input  m0_ack, m0_read_data, m0_read_data_valid, m0_error,
    input  m1_ack, m1_read_data, m1_read_data_valid, m1_error,
    input  s_addr, s_write_data, s_byte_enable, s_read_req, s_write_req
  );

  modport slave (
    input  m0_addr, m0_write_data, m0_byte_enable, m0_read_req, m0_write_req,
    input  m1_addr, m1_write_data, m1_byte_enable, m1_read_req, m1_write_req,
    input  s_read_data, s_read_data_valid,
    output m0_ack, m0_read_data, m0_read_data_valid, m0_error,
    output m1_ack, m1_read_data, m1_read_data_valid, m1_error,
    output s_addr, s_write_data, s_byte_enable, s_read_req, s_write_req
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter onto a single system bus follower port.
// Writes complete in the grant cycle; reads wait for data or a timeout.
module bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input logic           clk,
  input logic           reset,
  bus_arbiter_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] READ_WAIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             lastGrant_q, lastGrant_d;
  logic [CW-1:0]    waitCnt_q, waitCnt_d;
  logic [1:0][31:0] readData_q, readData_d;
  logic [1:0]       readValid_q, readValid_d;
  logic [1:0]       error_q, error_d;

  logic pend0, pend1, grant0, grant1, winRead, timedOut;

  // Reset also suppresses grants so no ack can escape during a reset cycle.
  assign pend0    = bus.m0_read_req | bus.m0_write_req;
  assign pend1    = bus.m1_read_req | bus.m1_write_req;
  assign grant0   = !reset && (state_q == IDLE) && pend0 && (!pend1 || lastGrant_q);
  assign grant1   = !reset && (state_q == IDLE) && pend1 && (!pend0 || !lastGrant_q);
  assign winRead  = grant0 ? (bus.m0_read_req & ~bus.m0_write_req)
                           : (bus.m1_read_req & ~bus.m1_write_req);
  assign timedOut = (waitCnt_q == CW'(TIMEOUT - 1));

  assign bus.m0_ack        = grant0;
  assign bus.m1_ack        = grant1;
  assign bus.s_addr        = grant0 ? bus.m0_addr : (grant1 ? bus.m1_addr : 32'h0);
  assign bus.s_write_data  = grant0 ? bus.m0_write_data : (grant1 ? bus.m1_write_data : 32'h0);
  assign bus.s_byte_enable = grant0 ? bus.m0_byte_enable : (grant1 ? bus.m1_byte_enable : 4'h0);
  assign bus.s_write_req   = (grant0 & bus.m0_write_req) | (grant1 & bus.m1_write_req);
  assign bus.s_read_req    = (grant0 | grant1) & winRead;

  assign bus.m0_read_data       = readData_q[0];
  assign bus.m1_read_data       = readData_q[1];
  assign bus.m0_read_data_valid = readValid_q[0];
  assign bus.m1_read_data_valid = readValid_q[1];
  assign bus.m0_error           = error_q[0];
  assign bus.m1_error           = error_q[1];

  // Valid data takes priority over the timeout on the final wait cycle.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    waitCnt_d   = waitCnt_q;
    readData_d  = readData_q;
    readValid_d = 2'b00;
    error_d     = 2'b00;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          lastGrant_d = grant1;
          if (winRead) begin
            state_d   = READ_WAIT;
            owner_d   = grant1;
            waitCnt_d = '0;
          end
        end
      end
      READ_WAIT: begin
        if (bus.s_read_data_valid) begin
          state_d                 = IDLE;
          readValid_d[owner_q]    = 1'b1;
          readData_d[owner_q]     = bus.s_read_data;
        end else if (timedOut) begin
          state_d                 = IDLE;
          readValid_d[owner_q]    = 1'b1;
          error_d[owner_q]        = 1'b1;
          readData_d[owner_q]     = 32'h0;
        end else begin
          waitCnt_d = waitCnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      waitCnt_q   <= '0;
      readData_q  <= '0;
      readValid_q <= 2'b00;
      error_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      waitCnt_q   <= waitCnt_d;
      readData_q  <= readData_d;
      readValid_q <= readValid_d;
      error_q     <= error_d;
    end
  end

endmodule
